adc_capture_seq: RTL
====================

# adc_capture_seq

Trigger-driven capture sequencer between the four-channel ADC front end and the PSRAM write FIFO. It latches each ADC sample set on `ad_strobe` and serialises it as four tagged 16-bit FIFO writes. Capture runs only after software/keypad arming and a trigger edge, and stops after a programmed number of post-trigger samples. Loss caused by FIFO backpressure or an unready PSRAM is reported, never hidden.

## Interface
- `NSAMP_W`, 16: width of post-trigger sample count and counters.
- `DROP_W`, 8: width of the saturating drop counter.

Ports:
- `clk`  in  1  48 MHz ADC/system clock; sole clock.
- `reset_n`  in  1  asynchronous, active-low reset; one clock.
- `ad_a0`, `ad_a1`, `ad_b0`, `ad_b1`  in  12 each  ADC results, valid when `ad_strobe`=1.
- `ad_strobe`  in  1  one-cycle sample-valid pulse; consecutive pulses are ≥8 cycles apart.
- `psram_ready`  in  1  PSRAM controller initialised.
- `arm`  in  1  one-cycle arm request.
- `abort`  in  1  one-cycle abort request.
- `trigger`  in  1  asynchronous trigger level (fire button); rising edge is the trigger event.
- `post_count`  in  NSAMP_W  samples to capture after trigger; sampled on `arm`.
- `fifo_full`  in  1  write FIFO cannot accept 4 more words.
- `wrfifo`  out  1  FIFO write enable.
- `wrfifo_data`  out  16  FIFO write word.
- `armed`  out  1  state is ARMED.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `overflow`  out  1  sticky: at least one sample dropped since last `arm`.
- `sample_count`  out  NSAMP_W  samples written in current/last capture.
- `drop_count`  out  DROP_W  saturating count of dropped samples since last `arm`.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE: `arm`=1 and `psram_ready`=1 → ARMED. On that edge:
  - latch `post_count` into `limit`;
  - clear `sample_count`, `drop_count` and `overflow`.
- `arm` in IDLE with `psram_ready`=0 is ignored. `arm` in any other state is ignored.
- ARMED: `trigger` goes through a 2-flop synchroniser, then a registered rising-edge detect.
  - On an edge with `limit`≠0 → CAPTURE.
  - On an edge with `limit`=0 → DONE; no words are written.
- CAPTURE: on each `ad_strobe` with the burst engine idle:
  - Accept the sample when `fifo_full`=0 and `psram_ready`=1. Latch all four channels and start a 4-word burst.
  - Otherwise drop it: `drop_count` increments (saturating at all-ones) and `overflow` sets.
  - A strobe arriving while a burst is in progress is also a drop.
- Burst word order: a0, a1, b0, b1. Word format: [15:14] channel index (0..3), [13:12] = 2'b00, [11:0] data.
- `sample_count` increments on the cycle the 4th word is written.
- When the incremented count equals `limit` → DONE on the next cycle.
- DONE: `done`=1 for exactly one cycle, then IDLE. `sample_count` holds until the next `arm`.
- `abort`:
  - In ARMED → IDLE next cycle, with no `done`.
  - In CAPTURE with no burst active → IDLE next cycle.
  - In CAPTURE mid-burst → the burst completes (groups stay 4-word aligned for 8-word PSRAM bursts), then IDLE.
  - Abort never pulses `done`.
- `ad_strobe` in IDLE, ARMED or DONE is ignored and is not a drop.
- Counter arithmetic is unsigned NSAMP_W bits. `limit` = 2^NSAMP_W−1 is the maximum; there is no wrap.

## Timing
- All outputs are registered.
- Reset (async assert, sync-free deassert allowed): state IDLE; `wrfifo`, `wrfifo_data`, `armed`, `busy`, `done`, `overflow`, `sample_count`, `drop_count` all 0.
- `arm` at cycle t → `armed`=`busy`=1 at t+1.
- `trigger` rises before clock edge t → state CAPTURE visible at t+3 (2 sync flops + edge register).
- A strobe coincident with the transition cycle belongs to the old state.
- Accepted `ad_strobe` at cycle t → `wrfifo`=1 at t+1..t+4 with a0, a1, b0, b1.
- Last-sample `sample_count` update is at t+4; state DONE and `done`=1 at t+5; IDLE at t+6.
- `fifo_full` is checked only at the strobe cycle. A burst in progress is never interrupted; the FIFO threshold guarantees 4 words of space.
- `psram_ready` falling mid-capture: later strobes are dropped and the state stays CAPTURE until `abort` or the limit is reached.
- `abort` and `ad_strobe` in the same cycle with no burst active: abort wins and the sample is not written or counted.

## Test plan
- Reset mid-burst: assert `reset_n`=0 during word 2 → `wrfifo` low immediately, all outputs 0, state IDLE.
- Basic capture: `post_count`=3, arm, trigger, 3 strobes with a0=0x123, a1=0x456, b0=0x789, b1=0xABC → 12 writes 0x0123, 0x4456, 0x8789, 0xCABC repeated; `done` pulse 1 cycle after last write; `sample_count`=3.
- Backpressure: `post_count`=4, `fifo_full`=1 on 2nd strobe → 2nd sample dropped, `overflow`=1, `drop_count`=1, capture ends after 5th strobe, `sample_count`=4.
- Zero limit and pre-trigger: `post_count`=0, strobes while ARMED → no writes; trigger → `done` pulse, `sample_count`=0.
- Abort mid-burst: abort on word 2 → words 3–4 still written, IDLE next, no `done`; abort while ARMED → IDLE at t+1.
- Ignored arm: arm with `psram_ready`=0 → stays IDLE; 300 dropped strobes → `drop_count` saturates at 255.

Source files
------------

// File: rtl/adc_capture_seq.sv
// adc_capture_seq: trigger-armed capture sequencer that turns each ADC
// sample set into four tagged 16-bit writes to the PSRAM write FIFO.
module adc_capture_seq #(
    parameter int NSAMP_W = 16,
    parameter int DROP_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [11:0]        ad_a0,
    input  logic [11:0]        ad_a1,
    input  logic [11:0]        ad_b0,
    input  logic [11:0]        ad_b1,
    input  logic               ad_strobe,
    input  logic               psram_ready,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger,
    input  logic [NSAMP_W-1:0] post_count,
    input  logic               fifo_full,
    output logic               wrfifo,
    output logic [15:0]        wrfifo_data,
    output logic               armed,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [NSAMP_W-1:0] sample_count,
    output logic [DROP_W-1:0]  drop_count
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t state;
    state_t state_nx;

    logic trig_s1;
    logic trig_s2;
    logic trig_s3;
    logic trig_edge;

    logic [NSAMP_W-1:0] limit;
    logic               burst_on;
    logic [1:0]         burst_idx;
    logic               abort_pend;
    logic [11:0]        hold_a1;
    logic [11:0]        hold_b0;
    logic [11:0]        hold_b1;

    logic        start_arm;
    logic        stop_now;
    logic        accept;
    logic        drop;
    logic        last_word;
    logic [15:0] word_nx;
    logic        armed_nx;
    logic        busy_nx;
    logic        done_nx;

    assign start_arm = (state == IDLE) && arm && psram_ready;

    // Abort or a reached limit closes the capture window to new samples.
    assign stop_now = abort || abort_pend || (sample_count == limit);

    assign accept = (state == CAPTURE) && !burst_on && ad_strobe
                  && !stop_now && !fifo_full && psram_ready;

    // A strobe during a burst is always lost; otherwise only backpressure
    // or an unready PSRAM loses it.
    assign drop = (state == CAPTURE) && ad_strobe
                && (burst_on || (!stop_now && (fifo_full || !psram_ready)));

    assign last_word = burst_on && (burst_idx == 2'd3);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state decode; bursts in flight always finish before leaving CAPTURE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_arm) state_nx = ARMED;
            end
            ARMED: begin
                if (abort)
                    state_nx = IDLE;
                else if (trig_edge)
                    state_nx = (limit == '0) ? DONE : CAPTURE;
            end
            CAPTURE: begin
                if (!burst_on) begin
                    if (abort || abort_pend)
                        state_nx = IDLE;
                    else if (sample_count == limit)
                        state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status flags follow the state that the next edge lands in
    always_comb begin
        armed_nx = (state_nx == ARMED);
        busy_nx  = (state_nx != IDLE);
        done_nx  = (state_nx == DONE);
    end

    // Trigger synchroniser and registered rising-edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_s1   <= 1'b0;
            trig_s2   <= 1'b0;
            trig_s3   <= 1'b0;
            trig_edge <= 1'b0;
        end else begin
            trig_s1   <= trigger;
            trig_s2   <= trig_s1;
            trig_s3   <= trig_s2;
            trig_edge <= trig_s2 & ~trig_s3;
        end
    end

    // Word for the next FIFO write: a0 straight from the ADC, rest held
    always_comb begin
        word_nx = wrfifo_data;
        if (accept) begin
            word_nx = {2'd0, 2'b00, ad_a0};
        end else if (burst_on) begin
            case (burst_idx)
                2'd1:    word_nx = {2'd1, 2'b00, hold_a1};
                2'd2:    word_nx = {2'd2, 2'b00, hold_b0};
                default: word_nx = {2'd3, 2'b00, hold_b1};
            endcase
        end
    end

    // Burst engine and registered FIFO/status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_on    <= 1'b0;
            burst_idx   <= 2'd0;
            abort_pend  <= 1'b0;
            hold_a1     <= '0;
            hold_b0     <= '0;
            hold_b1     <= '0;
            wrfifo      <= 1'b0;
            wrfifo_data <= '0;
            armed       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            wrfifo      <= accept | burst_on;
            wrfifo_data <= word_nx;
            armed       <= armed_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            abort_pend  <= (state_nx == CAPTURE)
                         && (abort_pend || (burst_on && abort));
            if (accept) begin
                hold_a1   <= ad_a1;
                hold_b0   <= ad_b0;
                hold_b1   <= ad_b1;
                burst_on  <= 1'b1;
                burst_idx <= 2'd1;
            end else if (burst_on) begin
                burst_idx <= burst_idx + 2'd1;
                if (last_word) burst_on <= 1'b0;
            end
        end
    end

    // Capture limit, sample counter and saturating loss accounting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            limit        <= '0;
            sample_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else if (start_arm) begin
            limit        <= post_count;
            sample_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            if (last_word)
                sample_count <= sample_count + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule
